// File: rtl/cg_index_decoder.sv
`default_nettype none
// ============================================================================
// Module  : cg_index_decoder
// Brief   : Rebuilds a bit mask from a framed valid/ready stream of bit
//           indices; flags duplicate and out-of-range indices per frame.
// Revision: 1.0
// ============================================================================
module cg_index_decoder #(
    parameter  int BITS_WIDTH  = 16,
    localparam int INDEX_WIDTH = $clog2(BITS_WIDTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [INDEX_WIDTH-1:0] i_index,
    input  logic                   i_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [BITS_WIDTH-1:0]  o_bits,
    output logic                   o_en,
    output logic                   o_dup,
    output logic                   o_oor
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        WAIT  = 1'b1
    } state_t;

    // One extra bit so a limit equal to 2**INDEX_WIDTH is representable.
    localparam logic [INDEX_WIDTH:0] BITS_LIMIT = (INDEX_WIDTH + 1)'(BITS_WIDTH);

    state_t                  state;
    state_t                  state_next;
    logic [BITS_WIDTH-1:0]   acc;
    logic [BITS_WIDTH-1:0]   acc_next;
    logic                    acc_dup;
    logic                    acc_dup_next;
    logic                    acc_oor;
    logic                    acc_oor_next;
    logic [BITS_WIDTH-1:0]   bits_next;
    logic                    dup_next;
    logic                    oor_next;
    logic                    valid_next;

    logic [BITS_WIDTH-1:0]   dec;
    logic                    beat_dup;
    logic                    beat_oor;
    logic                    accept;
    logic                    out_free;

    // Out-of-range indices match no position, so dec is naturally zero.
    always_comb begin
        dec = '0;
        for (int i = 0; i < BITS_WIDTH; i++) begin
            if (i_index == INDEX_WIDTH'(i)) begin
                dec[i] = 1'b1;
            end
        end
    end

    assign beat_dup = |(acc & dec);
    assign beat_oor = ({1'b0, i_index} >= BITS_LIMIT);
    assign o_ready  = (state == ACCUM) && !i_rst;
    assign accept   = i_valid && o_ready;
    assign out_free = !o_valid || i_ready;
    assign o_en     = |o_bits;

    always_comb begin
        state_next   = state;
        acc_next     = acc;
        acc_dup_next = acc_dup;
        acc_oor_next = acc_oor;
        bits_next    = o_bits;
        dup_next     = o_dup;
        oor_next     = o_oor;
        valid_next   = o_valid;

        if (o_valid && i_ready) begin
            valid_next = 1'b0;
        end

        case (state)
            ACCUM: begin
                if (accept) begin
                    if (i_last && out_free) begin
                        bits_next    = acc | dec;
                        dup_next     = acc_dup | beat_dup;
                        oor_next     = acc_oor | beat_oor;
                        valid_next   = 1'b1;
                        acc_next     = '0;
                        acc_dup_next = 1'b0;
                        acc_oor_next = 1'b0;
                    end else begin
                        acc_next     = acc | dec;
                        acc_dup_next = acc_dup | beat_dup;
                        acc_oor_next = acc_oor | beat_oor;
                        if (i_last) begin
                            state_next = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                // Completed frame parked in acc until the output drains.
                if (o_valid && i_ready) begin
                    bits_next    = acc;
                    dup_next     = acc_dup;
                    oor_next     = acc_oor;
                    valid_next   = 1'b1;
                    acc_next     = '0;
                    acc_dup_next = 1'b0;
                    acc_oor_next = 1'b0;
                    state_next   = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ACCUM;
            acc     <= '0;
            acc_dup <= 1'b0;
            acc_oor <= 1'b0;
            o_bits  <= '0;
            o_dup   <= 1'b0;
            o_oor   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            acc_dup <= acc_dup_next;
            acc_oor <= acc_oor_next;
            o_bits  <= bits_next;
            o_dup   <= dup_next;
            o_oor   <= oor_next;
            o_valid <= valid_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cg_index_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_cg_index_decoder
// Brief   : Directed self-checking bench for cg_index_decoder (16 and 10 bit).
// Revision: 1.0
// ============================================================================
module tb_cg_index_decoder;

    logic        clk;
    logic        rst;

    logic        v16, rdy16, last16, ov16, ir16, en16, dup16, oor16;
    logic [3:0]  idx16;
    logic [15:0] bits16;

    logic        v10, rdy10, last10, ov10, ir10, en10, dup10, oor10;
    logic [3:0]  idx10;
    logic [9:0]  bits10;

    int passed;
    int total;

    cg_index_decoder #(.BITS_WIDTH(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(rdy16),
        .i_index(idx16), .i_last(last16), .o_valid(ov16), .i_ready(ir16),
        .o_bits(bits16), .o_en(en16), .o_dup(dup16), .o_oor(oor16)
    );

    cg_index_decoder #(.BITS_WIDTH(10)) dut10 (
        .i_clk(clk), .i_rst(rst), .i_valid(v10), .o_ready(rdy10),
        .i_index(idx10), .i_last(last10), .o_valid(ov10), .i_ready(ir10),
        .o_bits(bits10), .o_en(en10), .o_dup(dup10), .o_oor(oor10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send16(input logic [3:0] idx, input logic last);
        int n;
        n = 0;
        v16 = 1'b1; idx16 = idx; last16 = last;
        while (!rdy16 && n < 20) begin @(negedge clk); n++; end
        if (!rdy16) begin
            total++;
            $display("FAIL send16_timeout: o_ready=%b required 1", rdy16);
        end
        @(posedge clk);
        @(negedge clk);
        v16 = 1'b0;
    endtask

    task automatic send10(input logic [3:0] idx, input logic last);
        int n;
        n = 0;
        v10 = 1'b1; idx10 = idx; last10 = last;
        while (!rdy10 && n < 20) begin @(negedge clk); n++; end
        if (!rdy10) begin
            total++;
            $display("FAIL send10_timeout: o_ready=%b required 1", rdy10);
        end
        @(posedge clk);
        @(negedge clk);
        v10 = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (ov16 !== 1'b0) $display("FAIL rst_valid: got %b want 0", ov16); else passed++;
        total++; if (bits16 !== 16'h0000) $display("FAIL rst_bits: got %h want 0000", bits16); else passed++;
        total++; if ({en16, dup16, oor16} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {en16, dup16, oor16}); else passed++;
        total++; if (rdy16 !== 1'b0) $display("FAIL rst_ready: got %b want 0", rdy16); else passed++;
        rst = 1'b0;
        send16(4'd3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        total++; if (rdy16 !== 1'b0) $display("FAIL rst_mid_ready: got %b want 0", rdy16); else passed++;
        rst = 1'b0;
        send16(4'd5, 1'b1);
        total++; if (ov16 !== 1'b1) $display("FAIL rst_after_valid: got %b want 1", ov16); else passed++;
        total++; if (bits16 !== 16'h0020) $display("FAIL rst_after_bits: got %h want 0020", bits16); else passed++;
        total++; if (dup16 !== 1'b0) $display("FAIL rst_after_dup: got %b want 0", dup16); else passed++;
        @(negedge clk);
        total++; if (ov16 !== 1'b0) $display("FAIL rst_consume_valid: got %b want 0", ov16); else passed++;
    endtask

    task automatic test_frame;
        send16(4'd0, 1'b0);
        send16(4'd7, 1'b0);
        send16(4'd15, 1'b1);
        total++; if (ov16 !== 1'b1) $display("FAIL frame_valid: got %b want 1", ov16); else passed++;
        total++; if (bits16 !== 16'h8081) $display("FAIL frame_bits: got %h want 8081", bits16); else passed++;
        total++; if ({en16, dup16, oor16} !== 3'b100) $display("FAIL frame_flags: got %b want 100", {en16, dup16, oor16}); else passed++;
        @(negedge clk);
    endtask

    task automatic test_dup;
        send16(4'd4, 1'b0);
        send16(4'd4, 1'b1);
        total++; if (bits16 !== 16'h0010) $display("FAIL dup_bits: got %h want 0010", bits16); else passed++;
        total++; if ({en16, dup16, oor16} !== 3'b110) $display("FAIL dup_flags: got %b want 110", {en16, dup16, oor16}); else passed++;
        @(negedge clk);
    endtask

    task automatic test_oor;
        send10(4'd12, 1'b0);
        send10(4'd2, 1'b1);
        total++; if (ov10 !== 1'b1) $display("FAIL oor_valid: got %b want 1", ov10); else passed++;
        total++; if (bits10 !== 10'h004) $display("FAIL oor_bits: got %h want 004", bits10); else passed++;
        total++; if ({en10, dup10, oor10} !== 3'b101) $display("FAIL oor_flags: got %b want 101", {en10, dup10, oor10}); else passed++;
        send10(4'd11, 1'b1);
        total++; if (ov10 !== 1'b1) $display("FAIL oor_only_valid: got %b want 1", ov10); else passed++;
        total++; if (bits10 !== 10'h000) $display("FAIL oor_only_bits: got %h want 000", bits10); else passed++;
        total++; if ({en10, dup10, oor10} !== 3'b001) $display("FAIL oor_only_flags: got %b want 001", {en10, dup10, oor10}); else passed++;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        ir16 = 1'b0;
        send16(4'd1, 1'b1);
        total++; if (ov16 !== 1'b1) $display("FAIL bp_a_valid: got %b want 1", ov16); else passed++;
        total++; if (bits16 !== 16'h0002) $display("FAIL bp_a_bits: got %h want 0002", bits16); else passed++;
        send16(4'd2, 1'b0);
        send16(4'd3, 1'b1);
        total++; if (rdy16 !== 1'b0) $display("FAIL bp_wait_ready: got %b want 0", rdy16); else passed++;
        total++; if (bits16 !== 16'h0002) $display("FAIL bp_wait_bits: got %h want 0002", bits16); else passed++;
        @(negedge clk);
        total++; if ({ov16, rdy16, bits16} !== {1'b1, 1'b0, 16'h0002}) $display("FAIL bp_hold: got v=%b r=%b bits=%h want v=1 r=0 bits=0002", ov16, rdy16, bits16); else passed++;
        ir16 = 1'b1;
        @(negedge clk);
        total++; if (bits16 !== 16'h000c) $display("FAIL bp_b_bits: got %h want 000c", bits16); else passed++;
        total++; if ({ov16, rdy16} !== 2'b11) $display("FAIL bp_b_vr: got %b want 11", {ov16, rdy16}); else passed++;
        @(negedge clk);
        total++; if (ov16 !== 1'b0) $display("FAIL bp_drain_valid: got %b want 0", ov16); else passed++;
    endtask

    task automatic test_streaming;
        ir16 = 1'b1;
        v16 = 1'b1; idx16 = 4'd0; last16 = 1'b1;
        @(negedge clk);
        total++; if ({ov16, rdy16, bits16} !== {1'b1, 1'b1, 16'h0001}) $display("FAIL stream0: got v=%b r=%b bits=%h want v=1 r=1 bits=0001", ov16, rdy16, bits16); else passed++;
        idx16 = 4'd1;
        @(negedge clk);
        total++; if ({ov16, rdy16, bits16} !== {1'b1, 1'b1, 16'h0002}) $display("FAIL stream1: got v=%b r=%b bits=%h want v=1 r=1 bits=0002", ov16, rdy16, bits16); else passed++;
        idx16 = 4'd2;
        @(negedge clk);
        total++; if ({ov16, rdy16, bits16} !== {1'b1, 1'b1, 16'h0004}) $display("FAIL stream2: got v=%b r=%b bits=%h want v=1 r=1 bits=0004", ov16, rdy16, bits16); else passed++;
        v16 = 1'b0;
        @(negedge clk);
        total++; if (ov16 !== 1'b0) $display("FAIL stream_end_valid: got %b want 0", ov16); else passed++;
    endtask

    task automatic test_idle_index;
        v16 = 1'b0; idx16 = 4'd9; last16 = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (ov16 !== 1'b0) $display("FAIL idle_valid: got %b want 0", ov16); else passed++;
        send16(4'd6, 1'b1);
        total++; if (bits16 !== 16'h0040) $display("FAIL idle_bits: got %h want 0040", bits16); else passed++;
        total++; if (dup16 !== 1'b0) $display("FAIL idle_dup: got %b want 0", dup16); else passed++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        v16 = 1'b0; idx16 = '0; last16 = 1'b0; ir16 = 1'b1;
        v10 = 1'b0; idx10 = '0; last10 = 1'b0; ir10 = 1'b1;
        test_reset();
        test_frame();
        test_dup();
        test_oor();
        test_backpressure();
        test_streaming();
        test_idle_index();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
